// File: rtl/cu_read_command_buffer_control_pkg.sv
// ---------------------------------------------------------------------------
// cu_read_command_buffer_control_pkg
// Shared types and constants for the read command buffer that sits between
// cu_control and the AFU command arbiter.
//   CU_READ_CMD_BUF_DEPTH          total entries (RAM entries + head register)
//   CU_READ_CMD_BUF_ALFULL_MARGIN  slack kept free when alfull asserts
//   head_state_t                   head register FSM states
//   CommandBufferPayload           command fields carried through the buffer
//   CommandBufferLine              payload qualified by a valid bit
//   BufferStatus                   {valid, alfull, full, empty}
// ---------------------------------------------------------------------------
package cu_read_command_buffer_control_pkg;

  localparam int CU_READ_CMD_BUF_DEPTH         = 32;
  localparam int CU_READ_CMD_BUF_ALFULL_MARGIN = 4;

  typedef enum logic {
    H_EMPTY = 1'b0,
    H_VALID = 1'b1
  } head_state_t;

  typedef struct packed {
    logic [7:0]  cu_id;
    logic [7:0]  tag;
    logic [12:0] command;
    logic [31:0] address;
  } CommandBufferPayload;

  typedef struct packed {
    logic                valid;
    CommandBufferPayload payload;
  } CommandBufferLine;

  typedef struct packed {
    logic valid;
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

endpackage

// File: rtl/cu_read_command_buffer_control_if.sv
// ---------------------------------------------------------------------------
// cu_read_command_buffer_control_if
// Command path of the read command buffer.
//   read_command_in   command from cu_control, .valid qualifies a push
//   command_ready_in  arbiter accepts read_command_out this cycle
//   read_command_out  head command, .valid means a head is present
// Modports:
//   master  the surrounding logic (cu_control + arbiter side)
//   slave   the buffer itself
// ---------------------------------------------------------------------------
interface cu_read_command_buffer_control_if;
  import cu_read_command_buffer_control_pkg::*;

  CommandBufferLine read_command_in;
  logic             command_ready_in;
  CommandBufferLine read_command_out;

  modport master (
    output read_command_in,
    output command_ready_in,
    input  read_command_out
  );

  modport slave (
    input  read_command_in,
    input  command_ready_in,
    output read_command_out
  );

endinterface

// File: rtl/cu_read_command_buffer_ram.sv
// ---------------------------------------------------------------------------
// cu_read_command_buffer_ram
// Simple dual-port storage for queued command payloads behind the head
// register. Registered write, asynchronous read so the head can be refilled
// in the same cycle it pops.
//   clock    write clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write payload
//   rd_addr  read address
//   rd_data  read payload (combinational)
// ---------------------------------------------------------------------------
module cu_read_command_buffer_ram #(
  parameter int WIDTH  = 61,
  parameter int DEPTH  = 31,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cu_read_command_buffer_control.sv
// ---------------------------------------------------------------------------
// cu_read_command_buffer_control
// Buffers read commands from cu_control ahead of the AFU command arbiter and
// presents one command at a time through a valid/ready handshake. Storage is
// DEPTH-1 RAM entries plus one head register, so DEPTH commands fit in total.
// A push arriving while full is dropped and sets a sticky overflow flag.
//   clock               single clock, posedge
//   rst_in              asynchronous active-high reset
//   enabled_in          pushes accepted only while high
//   cmd_if              read_command_in / command_ready_in / read_command_out
//   read_buffer_status  registered {valid, alfull, full, empty}
//   occupancy_out       entries held, head register included
//   overflow_out        sticky, set by a push attempted while full
// ---------------------------------------------------------------------------
module cu_read_command_buffer_control
  import cu_read_command_buffer_control_pkg::*;
#(
  parameter int DEPTH         = CU_READ_CMD_BUF_DEPTH,
  parameter int ALFULL_MARGIN = CU_READ_CMD_BUF_ALFULL_MARGIN
) (
  input  logic                      clock,
  input  logic                      rst_in,
  input  logic                      enabled_in,
  cu_read_command_buffer_control_if.slave cmd_if,
  output BufferStatus               read_buffer_status,
  output logic [$clog2(DEPTH):0]    occupancy_out,
  output logic                      overflow_out
);

  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int PTR_W     = $clog2(RAM_DEPTH);
  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam int PAY_W     = $bits(CommandBufferPayload);

  head_state_t         head_state;
  head_state_t         head_state_next;
  CommandBufferPayload head_payload;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  BufferStatus         status_r;
  logic                overflow_r;

  logic                head_valid;
  logic                ram_empty;
  logic                push;
  logic                pop;
  logic                load_from_ram;
  logic                load_from_push;
  logic                ram_wr_en;
  logic [PAY_W-1:0]    ram_rd_data;

  // Pointers wrap at the RAM size, which is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RAM_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign head_valid = (head_state == H_VALID);
  // The count includes the head register, so the RAM is empty when only the
  // head (or nothing) is accounted for.
  assign ram_empty  = (cnt == CNT_W'(head_valid));
  // Full comes from last cycle's registered count, so a push at full is
  // dropped even if a pop frees a slot in the same cycle.
  assign push       = cmd_if.read_command_in.valid & enabled_in & ~status_r.full;
  assign pop        = head_valid & cmd_if.command_ready_in;

  // Head register decisions: refill from RAM has priority over bypassing
  // the incoming command, which keeps ordering strictly FIFO.
  always_comb begin
    head_state_next = head_state;
    load_from_ram   = 1'b0;
    load_from_push  = 1'b0;
    case (head_state)
      H_EMPTY: begin
        if (!ram_empty) begin
          load_from_ram   = 1'b1;
          head_state_next = H_VALID;
        end else if (push) begin
          load_from_push  = 1'b1;
          head_state_next = H_VALID;
        end
      end
      H_VALID: begin
        if (pop) begin
          if (!ram_empty) begin
            load_from_ram   = 1'b1;
          end else if (push) begin
            load_from_push  = 1'b1;
          end else begin
            head_state_next = H_EMPTY;
          end
        end
      end
      default: head_state_next = H_EMPTY;
    endcase
  end

  assign ram_wr_en = push & ~load_from_push;

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
  end

  cu_read_command_buffer_ram #(
    .WIDTH  (PAY_W),
    .DEPTH  (RAM_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (cmd_if.read_command_in.payload),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // Head FSM, pointers, count, status and overflow all update together so
  // every output is taken straight from a register.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      head_state   <= H_EMPTY;
      head_payload <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      status_r     <= '{valid: 1'b0, alfull: 1'b0, full: 1'b0, empty: 1'b1};
      overflow_r   <= 1'b0;
    end else begin
      head_state <= head_state_next;
      if (load_from_ram) begin
        head_payload <= CommandBufferPayload'(ram_rd_data);
        rd_ptr       <= ptr_inc(rd_ptr);
      end else if (load_from_push) begin
        head_payload <= cmd_if.read_command_in.payload;
      end
      if (ram_wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      cnt             <= cnt_next;
      status_r.valid  <= 1'b1;
      status_r.empty  <= (cnt_next == '0);
      status_r.full   <= (cnt_next == CNT_W'(DEPTH));
      status_r.alfull <= (cnt_next >= CNT_W'(DEPTH - ALFULL_MARGIN));
      if (cmd_if.read_command_in.valid & enabled_in & status_r.full) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign cmd_if.read_command_out.valid   = head_valid;
  assign cmd_if.read_command_out.payload = head_payload;
  assign read_buffer_status              = status_r;
  assign occupancy_out                   = cnt;
  assign overflow_out                    = overflow_r;

endmodule

// File: tb/tb_cu_read_command_buffer_control.sv
// ---------------------------------------------------------------------------
// tb_cu_read_command_buffer_control
// Directed self-checking bench for the read command buffer: single command,
// fill/overflow/drain, steady push+pop with pointer wrap, random
// backpressure, enable gating and asynchronous reset mid-drain.
// ---------------------------------------------------------------------------
module tb_cu_read_command_buffer_control;
  import cu_read_command_buffer_control_pkg::*;

  localparam int DEPTH = 32;

  logic        clock = 1'b0;
  logic        rst_in = 1'b0;
  logic        enabled_in = 1'b0;
  BufferStatus read_buffer_status;
  logic [5:0]  occupancy_out;
  logic        overflow_out;

  int checks = 0;
  int errors = 0;

  cu_read_command_buffer_control_if cmd_bus ();

  cu_read_command_buffer_control dut (
    .clock              (clock),
    .rst_in             (rst_in),
    .enabled_in         (enabled_in),
    .cmd_if             (cmd_bus.slave),
    .read_buffer_status (read_buffer_status),
    .occupancy_out      (occupancy_out),
    .overflow_out       (overflow_out)
  );

  always #5 clock = ~clock;

  // Payload derived from the tag so that every field can be checked.
  function automatic CommandBufferPayload make_payload(input logic [7:0] tag);
    CommandBufferPayload p;
    p.cu_id   = 8'h03;
    p.tag     = tag;
    p.command = 13'h100 + 13'(tag);
    p.address = {tag, ~tag, tag ^ 8'h5A, 8'hC3};
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, then return 1ns after the active edge.
  task automatic applyStimulus(input logic push_valid, input logic [7:0] tag,
                               input logic ready, input logic en);
    CommandBufferLine line;
    line.valid   = push_valid;
    line.payload = make_payload(tag);
    cmd_bus.read_command_in  = line;
    cmd_bus.command_ready_in = ready;
    enabled_in               = en;
    @(posedge clock);
    #1;
  endtask

  task automatic checkHead(input string name, input logic [7:0] tag);
    CommandBufferPayload want;
    want = make_payload(tag);
    checkOutput({name, "_valid"}, 64'(cmd_bus.read_command_out.valid), 64'd1);
    checkOutput({name, "_tag"}, 64'(cmd_bus.read_command_out.payload.tag), 64'(tag));
    checkOutput({name, "_addr"}, 64'(cmd_bus.read_command_out.payload.address),
                64'(want.address));
  endtask

  task automatic doReset();
    @(negedge clock);
    rst_in = 1'b1;
    @(negedge clock);
    rst_in = 1'b0;
  endtask

  initial begin
    int exp_tag;
    logic rdy;
    cmd_bus.read_command_in  = '0;
    cmd_bus.command_ready_in = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_valid", 64'(cmd_bus.read_command_out.valid), 64'd0);
    checkOutput("rst_payload", 64'(cmd_bus.read_command_out.payload), 64'd0);
    checkOutput("rst_status", 64'(read_buffer_status), 64'b0001);
    checkOutput("rst_occ", 64'(occupancy_out), 64'd0);
    checkOutput("rst_ovf", 64'(overflow_out), 64'd0);
    @(negedge clock);
    rst_in = 1'b0;

    $display("[TB] T1 single command");
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b1);
    checkHead("t1_head", 8'd5);
    checkOutput("t1_status", 64'(read_buffer_status), 64'b1000);
    checkOutput("t1_occ", 64'(occupancy_out), 64'd1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("t1_drained", 64'(cmd_bus.read_command_out.valid), 64'd0);
    checkOutput("t1_empty", 64'(read_buffer_status), 64'b1001);
    checkOutput("t1_occ_end", 64'(occupancy_out), 64'd0);

    $display("[TB] T2 fill, overflow, drain");
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b1);
      checkOutput("t2_occ", 64'(occupancy_out), 64'(k + 1));
      checkOutput("t2_alfull", 64'(read_buffer_status.alfull), 64'((k + 1) >= 28));
      checkOutput("t2_full", 64'(read_buffer_status.full), 64'((k + 1) == 32));
    end
    checkHead("t2_head0", 8'd0);
    checkOutput("t2_ovf_before", 64'(overflow_out), 64'd0);
    applyStimulus(1'b1, 8'd32, 1'b0, 1'b1);
    checkOutput("t2_ovf", 64'(overflow_out), 64'd1);
    checkOutput("t2_occ_ovf", 64'(occupancy_out), 64'd32);
    // Pop while full: the simultaneous push must still be dropped.
    applyStimulus(1'b1, 8'd33, 1'b1, 1'b1);
    checkOutput("t2_occ_poppush", 64'(occupancy_out), 64'd31);
    checkOutput("t2_status_31", 64'(read_buffer_status), 64'b1100);
    for (int i = 1; i < DEPTH; i++) begin
      checkHead("t2_drain", 8'(i));
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    end
    checkOutput("t2_end_valid", 64'(cmd_bus.read_command_out.valid), 64'd0);
    checkOutput("t2_end_occ", 64'(occupancy_out), 64'd0);
    checkOutput("t2_end_status", 64'(read_buffer_status), 64'b1001);
    checkOutput("t2_ovf_sticky", 64'(overflow_out), 64'd1);

    $display("[TB] T3 steady push and pop");
    doReset();
    checkOutput("t3_ovf_cleared", 64'(overflow_out), 64'd0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b1);
    end
    checkOutput("t3_occ_start", 64'(occupancy_out), 64'd10);
    for (int i = 0; i < 100; i++) begin
      checkHead("t3_stream", 8'(i));
      applyStimulus(1'b1, 8'(10 + i), 1'b1, 1'b1);
      checkOutput("t3_occ", 64'(occupancy_out), 64'd10);
    end
    for (int i = 100; i < 110; i++) begin
      checkHead("t3_tail", 8'(i));
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    end
    checkOutput("t3_occ_end", 64'(occupancy_out), 64'd0);

    $display("[TB] T4 backpressure");
    for (int k = 7; k <= 16; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b1);
    end
    exp_tag = 7;
    for (int c = 0; c < 50; c++) begin
      rdy = 1'($urandom_range(0, 1));
      if (exp_tag <= 16) begin
        checkHead("t4_head", 8'(exp_tag));
      end else begin
        checkOutput("t4_idle", 64'(cmd_bus.read_command_out.valid), 64'd0);
      end
      applyStimulus(1'b0, 8'd0, rdy, 1'b1);
      if (rdy && exp_tag <= 16) begin
        exp_tag++;
      end
    end
    while (exp_tag <= 16) begin
      checkHead("t4_finish", 8'(exp_tag));
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      exp_tag++;
    end
    checkOutput("t4_occ_end", 64'(occupancy_out), 64'd0);

    $display("[TB] T5 enable gating");
    for (int k = 20; k < 24; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b1);
    end
    checkOutput("t5_occ", 64'(occupancy_out), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkHead("t5_drain", 8'(20 + i));
      applyStimulus(1'b1, 8'd99, 1'b1, 1'b0);
    end
    checkOutput("t5_drained", 64'(cmd_bus.read_command_out.valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'd99, 1'b0, 1'b0);
    end
    checkOutput("t5_occ_end", 64'(occupancy_out), 64'd0);
    checkOutput("t5_ovf", 64'(overflow_out), 64'd0);
    checkOutput("t5_status", 64'(read_buffer_status), 64'b1001);

    $display("[TB] T6 reset mid-drain");
    for (int k = 40; k < 54; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("t6_occ_pre", 64'(occupancy_out), 64'd12);
    checkHead("t6_head_pre", 8'd42);
    cmd_bus.read_command_in  = '0;
    cmd_bus.command_ready_in = 1'b0;
    #3 rst_in = 1'b1;
    #1;
    checkOutput("t6_valid", 64'(cmd_bus.read_command_out.valid), 64'd0);
    checkOutput("t6_payload", 64'(cmd_bus.read_command_out.payload), 64'd0);
    checkOutput("t6_occ", 64'(occupancy_out), 64'd0);
    checkOutput("t6_status", 64'(read_buffer_status), 64'b0001);
    @(posedge clock);
    #3 rst_in = 1'b0;
    #1;
    checkOutput("t6_after_release", 64'(cmd_bus.read_command_out.valid), 64'd0);
    applyStimulus(1'b1, 8'd60, 1'b0, 1'b1);
    checkHead("t6_first", 8'd60);
    checkOutput("t6_occ_first", 64'(occupancy_out), 64'd1);
    checkOutput("t6_status_first", 64'(read_buffer_status), 64'b1000);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("t6_no_stale", 64'(cmd_bus.read_command_out.valid), 64'd0);
    checkOutput("t6_occ_end", 64'(occupancy_out), 64'd0);

    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule
